// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared types, constants and helpers for the serial frame receiver
package serial_rx_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        RECV  = 2'd1,
        PAR   = 2'd2,
        CHECK = 2'd3
    } rx_state_t;

    localparam int         MAX_PKT_W        = 128;
    localparam logic [5:0] DEFAULT_SYNC_PAT = 6'b011111;

    // Zero-extension is harmless here because padding bits do not change the XOR.
    function automatic logic parity_of(input logic [MAX_PKT_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_frame_rx_fifo.sv
// rtl/serial_frame_rx_fifo.sv - small synchronous FIFO with registered head and push/pop arbitration
module sync_fifo #(
    parameter int WIDTH = 55,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop_ready,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_pop;
    logic             w_push;
    logic             w_full;

    assign w_full = (r_count == DEPTH[PTR_W:0]);
    assign w_pop  = i_pop_ready && (r_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_full  = w_full;

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - sync-hunting serial frame receiver with parity check and buffered output
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int                PKT_W      = 55,
    parameter int                SYNC_W     = 6,
    parameter logic [SYNC_W-1:0] SYNC_PAT   = SYNC_W'(DEFAULT_SYNC_PAT),
    parameter int                PARITY_EN  = 1,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_data,
    output logic [PKT_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          par_err,
    output logic                          ovf_err
);

    localparam int CNT_W = $clog2(PKT_W);

    rx_state_t          r_state;
    rx_state_t          w_next_state;
    logic [SYNC_W-1:0]  r_sync_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic [PKT_W-1:0]   r_pkt;
    logic               r_par;
    logic               r_par_err;
    logic               r_ovf_err;

    logic [MAX_PKT_W-1:0] w_pkt_ext;
    logic               w_sync_hit;
    logic               w_in_check;
    logic               w_parity_bad;
    logic               w_good;
    logic               w_pop;
    logic               w_fifo_full;
    logic               w_push_req;
    logic               w_ovf;

    assign w_sync_hit = (r_sync_sr == SYNC_PAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            HUNT: begin
                if (w_sync_hit) begin
                    w_next_state = RECV;
                end
            end
            RECV: begin
                if (r_cnt == '0) begin
                    w_next_state = (PARITY_EN != 0) ? PAR : CHECK;
                end
            end
            PAR:     w_next_state = CHECK;
            CHECK:   w_next_state = HUNT;
            default: w_next_state = HUNT;
        endcase
    end

    always_comb begin
        w_pkt_ext               = '0;
        w_pkt_ext[PKT_W-1:0]    = r_pkt;
        busy                    = (r_state != HUNT);
        w_in_check              = (r_state == CHECK);
        w_parity_bad            = (PARITY_EN != 0) && (parity_of(w_pkt_ext) ^ r_par);
        w_good                  = !w_parity_bad;
        w_pop                   = out_valid && out_ready;
        w_push_req              = w_in_check && w_good;
        w_ovf                   = w_push_req && w_fifo_full && !w_pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_sr <= '1;
            r_cnt     <= '0;
            r_pkt     <= '0;
            r_par     <= 1'b0;
            r_par_err <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            r_par_err <= 1'b0;
            r_ovf_err <= 1'b0;
            case (r_state)
                HUNT: begin
                    r_sync_sr <= {r_sync_sr[SYNC_W-2:0], s_data};
                    if (w_sync_hit) begin
                        r_pkt[PKT_W-1] <= s_data;
                        r_cnt          <= CNT_W'(PKT_W - 2);
                    end
                end
                RECV: begin
                    r_pkt[r_cnt] <= s_data;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                PAR: begin
                    r_par <= s_data;
                end
                CHECK: begin
                    // Fresh all-ones history keeps payload bits out of the next sync search.
                    r_sync_sr <= '1;
                    r_par_err <= w_in_check && w_parity_bad;
                    r_ovf_err <= w_ovf;
                end
                default: begin
                    r_sync_sr <= '1;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push_req),
        .i_push_data (r_pkt),
        .i_pop_ready (out_ready),
        .o_data      (out_data),
        .o_valid     (out_valid),
        .o_count     (fifo_count),
        .o_full      (w_fifo_full)
    );

    assign par_err = r_par_err;
    assign ovf_err = r_ovf_err;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - directed self-checking bench for serial_frame_rx
module tb_serial_frame_rx;

    logic        clk;
    logic        rst;
    logic        s_data;
    logic [54:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  fifo_count;
    logic        busy;
    logic        par_err;
    logic        ovf_err;

    int n_checks;
    int n_pass;
    int n_par_pulses;
    int n_ovf_pulses;
    int busy_seen;

    localparam logic [54:0] FA = 55'h40_0000_0000_0001;
    localparam logic [54:0] B1 = 55'h12_3456_789A_BCDE;
    localparam logic [54:0] B2 = 55'h7F_0000_FFFF_0000;
    localparam logic [54:0] B3 = 55'h00_1111_2222_3333;
    localparam logic [54:0] C1 = 55'h55_5555_5555_5555;
    localparam logic [54:0] C2 = 55'h2A_AAAA_AAAA_AAAA;
    localparam logic [54:0] C3 = 55'h01_0203_0405_0607;
    localparam logic [54:0] D1 = 55'h1F_1F1F_1F1F_1F1F;
    localparam logic [54:0] D2 = 55'h3E_0F80_7C1F_03E0;
    localparam logic [54:0] E1 = 55'h33_CC33_CC33_CC33;
    localparam logic [54:0] E2 = 55'h7F_FFFF_FFFF_FFFE;

    serial_frame_rx #(
        .PKT_W      (55),
        .SYNC_W     (6),
        .SYNC_PAT   (6'b011111),
        .PARITY_EN  (1),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .busy       (busy),
        .par_err    (par_err),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (par_err) n_par_pulses++;
        if (ovf_err) n_ovf_pulses++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        s_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sync();
        logic [5:0] sp;
        sp = 6'b011111;
        for (int i = 5; i >= 0; i--) send_bit(sp[i]);
    endtask

    // Leaves the receiver in its CHECK cycle, #1 after the last frame bit edge.
    task automatic send_frame(input logic [54:0] pkt, input logic par);
        send_sync();
        for (int i = 54; i >= 0; i--) send_bit(pkt[i]);
        send_bit(par);
    endtask

    task automatic full_frame(input logic [54:0] pkt);
        send_frame(pkt, ^pkt);
        send_bit(1'b1);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int par0;
        int ovf0;
        n_checks     = 0;
        n_pass       = 0;
        n_par_pulses = 0;
        n_ovf_pulses = 0;
        busy_seen    = 0;
        rst          = 1'b0;
        s_data       = 1'b1;
        out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_errs", 64'({par_err, ovf_err}), 64'd0);
        rst = 1'b1;
        repeat (4) send_bit(1'b1);

        // Good frame with default parameters
        send_frame(FA, 1'b0);
        check("good_busy_in_check", 64'(busy), 64'd1);
        check("good_valid_early", 64'(out_valid), 64'd0);
        send_bit(1'b1);
        check("good_valid", 64'(out_valid), 64'd1);
        check("good_data", 64'(out_data), 64'(FA));
        check("good_count", 64'(fifo_count), 64'd1);
        check("good_busy_after", 64'(busy), 64'd0);
        check("good_no_par_err", 64'(n_par_pulses), 64'd0);
        pop_one();
        check("good_pop_count", 64'(fifo_count), 64'd0);
        check("good_pop_valid", 64'(out_valid), 64'd0);

        // Bad parity
        send_frame(FA, 1'b1);
        send_bit(1'b1);
        check("bad_par_err_high", 64'(par_err), 64'd1);
        check("bad_valid", 64'(out_valid), 64'd0);
        send_bit(1'b1);
        check("bad_par_err_low", 64'(par_err), 64'd0);
        check("bad_count", 64'(fifo_count), 64'd0);
        check("bad_pulse_total", 64'(n_par_pulses), 64'd1);

        // Overflow with consumer stalled
        full_frame(B1);
        full_frame(B2);
        check("ovf_count_two", 64'(fifo_count), 64'd2);
        check("ovf_none_yet", 64'(n_ovf_pulses), 64'd0);
        full_frame(B3);
        check("ovf_err_high", 64'(ovf_err), 64'd1);
        check("ovf_count_full", 64'(fifo_count), 64'd2);
        send_bit(1'b1);
        check("ovf_err_low", 64'(ovf_err), 64'd0);
        check("ovf_pulse_total", 64'(n_ovf_pulses), 64'd1);
        check("ovf_head_1", 64'(out_data), 64'(B1));
        pop_one();
        check("ovf_head_2", 64'(out_data), 64'(B2));
        pop_one();
        check("ovf_drained", 64'(fifo_count), 64'd0);

        // Full FIFO with a pop in the CHECK cycle
        full_frame(C1);
        full_frame(C2);
        send_frame(C3, ^C3);
        out_ready = 1'b1;
        send_bit(1'b1);
        out_ready = 1'b0;
        check("fullpop_no_ovf", 64'(ovf_err), 64'd0);
        check("fullpop_count", 64'(fifo_count), 64'd2);
        check("fullpop_head_2", 64'(out_data), 64'(C2));
        pop_one();
        check("fullpop_head_3", 64'(out_data), 64'(C3));
        pop_one();
        check("fullpop_drained", 64'(fifo_count), 64'd0);
        check("fullpop_ovf_total", 64'(n_ovf_pulses), 64'd1);

        // Payload containing the sync pattern, frames back to back
        full_frame(D1);
        full_frame(D2);
        check("sync_count", 64'(fifo_count), 64'd2);
        check("sync_head_1", 64'(out_data), 64'(D1));
        pop_one();
        check("sync_head_2", 64'(out_data), 64'(D2));
        pop_one();
        repeat (10) send_bit(1'b1);
        check("sync_no_extra", 64'(fifo_count), 64'd0);

        // Idle line held high
        for (int i = 0; i < 200; i++) begin
            send_bit(1'b1);
            if (busy !== 1'b0) busy_seen++;
        end
        check("idle_never_busy", 64'(busy_seen), 64'd0);

        // Reset in the middle of a frame, with one frame already buffered
        full_frame(B1);
        par0 = n_par_pulses;
        ovf0 = n_ovf_pulses;
        send_sync();
        for (int i = 54; i >= 35; i--) send_bit(E1[i]);
        rst = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(fifo_count), 64'd0);
        check("midrst_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_bit(1'b1);
        full_frame(E2);
        check("midrst_next_valid", 64'(out_valid), 64'd1);
        check("midrst_next_data", 64'(out_data), 64'(E2));
        check("midrst_next_count", 64'(fifo_count), 64'd1);
        check("midrst_no_errs", 64'((n_par_pulses - par0) + (n_ovf_pulses - ovf0)), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
